// File: rtl/toplam_biriktirici_pkg.sv
// Shared definitions for the sum accumulator slice.
// Holds the two-state FSM encoding and the default sizing constants.
// Imported by the interface, the adder sub-module and the top.
package toplam_pkg;

  // TOPLA: collecting sums, SUN: holding a finished result for downstream
  typedef enum logic {
    TOPLA = 1'b0,
    SUN   = 1'b1
  } durum_e;

  localparam int ADET_VARSAYILAN     = 4;  // sums per result
  localparam int GENISLIK_VARSAYILAN = 8;  // accumulator / result width

endpackage

// File: rtl/toplam_biriktirici_if.sv
// Handshake bundle between upstream adder, accumulator and result consumer.
// Ports: Giris/giris_gecerli/giris_hazir (input side), temizle (clear),
//        Cikis/cikis_gecerli/cikis_hazir, tasma, sayac (result side).
interface toplam_biriktirici_if #(
  parameter int GENISLIK = toplam_pkg::GENISLIK_VARSAYILAN
);

  logic [4:0]          Giris;
  logic                giris_gecerli;
  logic                giris_hazir;
  logic                temizle;
  logic [GENISLIK-1:0] Cikis;
  logic                cikis_gecerli;
  logic                cikis_hazir;
  logic                tasma;
  logic [3:0]          sayac;

  // master: the environment driving sums and consuming results
  modport master (
    output Giris, giris_gecerli, temizle, cikis_hazir,
    input  giris_hazir, Cikis, cikis_gecerli, tasma, sayac
  );

  // slave: the accumulator itself
  modport slave (
    input  Giris, giris_gecerli, temizle, cikis_hazir,
    output giris_hazir, Cikis, cikis_gecerli, tasma, sayac
  );

endinterface

// File: rtl/toplam_biriktirici_toplayici.sv
// Combinational GENISLIK-bit adder: accumulator plus zero-extended 5-bit sum.
// Ports: a_i (accumulator), b_i (5-bit sum), toplam_o (wrapped sum),
//        tasma_o (carry out of the GENISLIK-bit addition).
module biriktirici_toplayici
  import toplam_pkg::*;
#(
  parameter int GENISLIK = GENISLIK_VARSAYILAN
) (
  input  logic [GENISLIK-1:0] a_i,
  input  logic [4:0]          b_i,
  output logic [GENISLIK-1:0] toplam_o,
  output logic                tasma_o
);

  // One extra bit on the left captures the carry out
  assign {tasma_o, toplam_o} = {1'b0, a_i} + {{(GENISLIK - 4){1'b0}}, b_i};

endmodule

// File: rtl/toplam_biriktirici.sv
// Accumulates ADET 5-bit sums into one GENISLIK-bit result with sticky overflow.
// Ports: clk, rst (async active-high), bus (slave side of toplam_biriktirici_if).
// Result appears 1 cycle after the last accept; input stalls until it transfers.
module toplam_biriktirici
  import toplam_pkg::*;
#(
  parameter int ADET     = ADET_VARSAYILAN,
  parameter int GENISLIK = GENISLIK_VARSAYILAN
) (
  input  logic               clk,
  input  logic               rst,
  toplam_biriktirici_if.slave bus
);

  localparam logic [3:0] SON_SAYAC = 4'(ADET - 1);

  durum_e              durum_q;
  logic [GENISLIK-1:0] acc_q;
  logic [GENISLIK-1:0] cikis_q;
  logic [3:0]          sayac_q;
  logic                tasma_q;
  logic                cikis_gecerli_q;

  logic [GENISLIK-1:0] toplam_d;
  logic                elde_d;
  logic                kabul;
  logic                aktarim;

  biriktirici_toplayici #(
    .GENISLIK (GENISLIK)
  ) u_toplayici (
    .a_i      (acc_q),
    .b_i      (bus.Giris),
    .toplam_o (toplam_d),
    .tasma_o  (elde_d)
  );

  // Ready is a pure state decode so upstream sees it without extra latency
  assign bus.giris_hazir = (durum_q == TOPLA);

  assign kabul   = bus.giris_gecerli & bus.giris_hazir;
  assign aktarim = cikis_gecerli_q & bus.cikis_hazir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q         <= TOPLA;
      acc_q           <= '0;
      cikis_q         <= '0;
      sayac_q         <= '0;
      tasma_q         <= 1'b0;
      cikis_gecerli_q <= 1'b0;
    end else begin
      case (durum_q)
        TOPLA: begin
          if (bus.temizle) begin
            // Clear wins over a coincident accept; that sum is dropped
            acc_q   <= '0;
            sayac_q <= '0;
            tasma_q <= 1'b0;
          end else if (kabul) begin
            acc_q   <= toplam_d;
            sayac_q <= sayac_q + 4'd1;
            tasma_q <= tasma_q | elde_d;
            if (sayac_q == SON_SAYAC) begin
              durum_q         <= SUN;
              cikis_q         <= toplam_d;
              cikis_gecerli_q <= 1'b1;
            end
          end
        end
        SUN: begin
          // Clear is ignored here so a finished result is never lost.
          // Cikis keeps the transferred value until the next result loads.
          if (aktarim) begin
            durum_q         <= TOPLA;
            acc_q           <= '0;
            sayac_q         <= '0;
            tasma_q         <= 1'b0;
            cikis_gecerli_q <= 1'b0;
          end
        end
        default: durum_q <= TOPLA;
      endcase
    end
  end

  assign bus.Cikis         = cikis_q;
  assign bus.cikis_gecerli = cikis_gecerli_q;
  assign bus.tasma         = tasma_q;
  assign bus.sayac         = sayac_q;

endmodule

// File: tb/tb_toplam_biriktirici.sv
// Bench for toplam_biriktirici: default instance (ADET=4) plus an ADET=10
// instance for the overflow case. Behavioural model tracks the unbounded sum
// of accepted inputs; outputs are compared against it every falling edge.
module tb_toplam_biriktirici;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  toplam_biriktirici_if #(.GENISLIK(8)) b1 ();
  toplam_biriktirici_if #(.GENISLIK(8)) b2 ();

  toplam_biriktirici u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  toplam_biriktirici #(
    .ADET     (10),
    .GENISLIK (8)
  ) u_dut10 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  int n_test = 0;
  int n_fail = 0;

  // Model of the default instance: unbounded running sum, count of accepted
  // sums in the current result, last transferred result, results delivered.
  int m_sum  = 0;
  int m_cnt  = 0;
  int m_last = 0;
  int m_res  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_test++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // A result is complete once 4 sums are held; the wrapped value is sum mod 256
  // and overflow means the true sum exceeded 255.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum  <= 0;
      m_cnt  <= 0;
      m_last <= 0;
    end else if (m_cnt == 4) begin
      if (b1.cikis_hazir) begin
        m_last <= m_sum % 256;
        m_sum  <= 0;
        m_cnt  <= 0;
        m_res  <= m_res + 1;
      end
    end else if (b1.temizle) begin
      m_sum <= 0;
      m_cnt <= 0;
    end else if (b1.giris_gecerli) begin
      m_sum <= m_sum + int'(b1.Giris);
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m_cikis_gecerli", 32'(b1.cikis_gecerli), int'(m_cnt == 4));
      check("m_giris_hazir",   32'(b1.giris_hazir),   int'(m_cnt != 4));
      check("m_sayac",         32'(b1.sayac),         m_cnt);
      check("m_tasma",         32'(b1.tasma),         int'(m_sum > 255));
      check("m_Cikis",         32'(b1.Cikis),         (m_cnt == 4) ? (m_sum % 256) : m_last);
    end
  end

  // Drive one cycle on the default instance, return 1 time unit after the edge
  task automatic cyc(input int v, input int g, input int hz, input int clr);
    b1.giris_gecerli = v[0];
    b1.Giris         = 5'(g);
    b1.cikis_hazir   = hz[0];
    b1.temizle       = clr[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    int n_cyc;

    b1.giris_gecerli = 1'b0; b1.Giris = '0; b1.cikis_hazir = 1'b0; b1.temizle = 1'b0;
    b2.giris_gecerli = 1'b0; b2.Giris = '0; b2.cikis_hazir = 1'b0; b2.temizle = 1'b0;

    #1 rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset values
    check("rst_giris_hazir",   32'(b1.giris_hazir),   1);
    check("rst_cikis_gecerli", 32'(b1.cikis_gecerli), 0);
    check("rst_Cikis",         32'(b1.Cikis),         0);
    check("rst_sayac",         32'(b1.sayac),         0);
    check("rst_tasma",         32'(b1.tasma),         0);

    // ADET=10 instance: ten sums of 30 wrap to 44 with overflow
    b2.giris_gecerli = 1'b1;
    b2.Giris         = 5'd30;
    repeat (10) @(posedge clk);
    #1;
    b2.giris_gecerli = 1'b0;
    check("a10_Cikis",   32'(b2.Cikis),         44);
    check("a10_tasma",   32'(b2.tasma),         1);
    check("a10_sayac",   32'(b2.sayac),         10);
    check("a10_gecerli", 32'(b2.cikis_gecerli), 1);
    b2.cikis_hazir = 1'b1;
    @(posedge clk);
    #1;
    b2.cikis_hazir = 1'b0;
    check("a10_tasma_clr", 32'(b2.tasma),         0);
    check("a10_gec_clr",   32'(b2.cikis_gecerli), 0);
    check("a10_hold",      32'(b2.Cikis),         44);

    // 5+10+15+30 back-to-back, consumer ready
    cyc(1, 5, 1, 0); cyc(1, 10, 1, 0); cyc(1, 15, 1, 0); cyc(1, 30, 1, 0);
    check("b2b_Cikis",   32'(b1.Cikis),         60);
    check("b2b_tasma",   32'(b1.tasma),         0);
    check("b2b_sayac",   32'(b1.sayac),         4);
    check("b2b_gecerli", 32'(b1.cikis_gecerli), 1);
    cyc(0, 0, 1, 0);
    check("b2b_hazir_after", 32'(b1.giris_hazir),   1);
    check("b2b_gec_after",   32'(b1.cikis_gecerli), 0);
    check("b2b_Cikis_hold",  32'(b1.Cikis),         60);

    // Stalled result, input offered but must be ignored
    cyc(1, 5, 0, 0); cyc(1, 10, 0, 0); cyc(1, 15, 0, 0); cyc(1, 30, 0, 0);
    repeat (3) begin
      cyc(1, 7, 0, 0);
      check("stall_Cikis", 32'(b1.Cikis),       60);
      check("stall_hazir", 32'(b1.giris_hazir), 0);
      check("stall_sayac", 32'(b1.sayac),       4);
    end
    cyc(1, 7, 1, 0);
    check("stall_xfer_gec",   32'(b1.cikis_gecerli), 0);
    check("stall_xfer_sayac", 32'(b1.sayac),         0);
    cyc(1, 7, 0, 0);
    check("stall_next_sayac", 32'(b1.sayac), 1);
    cyc(0, 0, 0, 1);
    check("clr_sayac", 32'(b1.sayac), 0);

    // Clear coinciding with a valid input discards it
    cyc(1, 20, 0, 0); cyc(1, 9, 0, 0);
    check("clr_pre_sayac", 32'(b1.sayac), 2);
    cyc(1, 3, 0, 1);
    check("clr_win_sayac", 32'(b1.sayac), 0);
    check("clr_win_tasma", 32'(b1.tasma), 0);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    check("clr_Cikis", 32'(b1.Cikis), 10);
    cyc(0, 0, 1, 0);

    // Asynchronous reset mid-accumulation and during SUN
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    check("ar_pre_sayac", 32'(b1.sayac), 2);
    #1 rst = 1'b1;
    #1;
    check("ar1_sayac", 32'(b1.sayac),       0);
    check("ar1_hazir", 32'(b1.giris_hazir), 1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    check("ar_sun_gec", 32'(b1.cikis_gecerli), 1);
    #1 rst = 1'b1;
    #1;
    check("ar2_gec",   32'(b1.cikis_gecerli), 0);
    check("ar2_Cikis", 32'(b1.Cikis),         0);
    check("ar2_sayac", 32'(b1.sayac),         0);
    check("ar2_hazir", 32'(b1.giris_hazir),   1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    check("ar_after_Cikis", 32'(b1.Cikis), 4);
    cyc(0, 0, 1, 0);

    // Random traffic until 1000 more results have been delivered
    start = m_res;
    n_cyc = 0;
    while ((m_res - start) < 1000 && n_cyc < 60000) begin
      cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 49) == 0));
      n_cyc++;
    end
    check("rand_results_done", 32'((m_res - start) >= 1000), 1);

    cyc(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/toplam_biriktirici.md
TOPLAM_BIRIKTIRICI -- requirements
Module: toplam_biriktirici

Interface
REQ-001 Parameter ADET, default 4: number of sums accumulated per result, legal range 2..15.
REQ-002 Parameter GENISLIK, default 8: accumulator and result width in bits, legal range 6..16.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 Giris  input  5  unsigned 5-bit sum (carry + 4 sum bits) from the upstream 4-bit adder stage.
REQ-007 giris_gecerli  input  1  Giris is valid this cycle.
REQ-008 giris_hazir  output  1  block accepts Giris this cycle.
REQ-009 temizle  input  1  synchronous clear of the partial accumulation.
REQ-010 Cikis  output  GENISLIK  accumulated result.
REQ-011 cikis_gecerli  output  1  Cikis is valid.
REQ-012 cikis_hazir  input  1  downstream consumes Cikis this cycle.
REQ-013 tasma  output  1  sticky overflow flag for the current result.
REQ-014 sayac  output  4  number of sums accepted into the current result.

Function
REQ-015 Two-state FSM: TOPLA (accumulating) and SUN (presenting the result).
REQ-016 giris_hazir = 1 in TOPLA and 0 in SUN; it is a combinational decode of state only.
REQ-017 Accept = giris_gecerli & giris_hazir; on accept, acc <= acc + zero-extended Giris (modulo 2^GENISLIK) and sayac <= sayac + 1.
REQ-018 A carry out of the accumulator addition sets tasma; tasma stays set until the result transfers, temizle is asserted, or reset.
REQ-019 An accept while sayac == ADET-1 moves the FSM to SUN at the same edge; Cikis loads the final sum and cikis_gecerli = 1 in the next cycle, giving a latency of 1 cycle from the last accept.
REQ-020 In SUN, Cikis, tasma and sayac (= ADET) hold stable while cikis_hazir = 0; Giris is ignored.
REQ-021 Transfer = cikis_gecerli & cikis_hazir; at that edge acc, sayac and tasma clear, cikis_gecerli drops, and the FSM returns to TOPLA; the next accept is possible in the following cycle.
REQ-022 temizle in TOPLA clears acc, sayac and tasma; when it coincides with an accept, temizle wins and that Giris is discarded.
REQ-023 temizle in SUN has no effect; a valid result is never dropped.
REQ-024 In TOPLA, Cikis holds the last transferred result; cikis_gecerli = 0.

Reset
REQ-025 rst asserted, at any time including mid-accumulation or in SUN: state = TOPLA, acc = 0, Cikis = 0, sayac = 0, tasma = 0, cikis_gecerli = 0, giris_hazir = 1 after release.
REQ-026 No partial result survives reset; the first accept after release starts a new result.

Structure
REQ-027 Shared package toplam_pkg holds the FSM state enum (TOPLA, SUN) and the default ADET and GENISLIK constants.
REQ-028 One sub-module, biriktirici_toplayici: a GENISLIK-bit combinational adder returning sum and carry out, instantiated once for the acc + Giris path.

Verification
REQ-029 Defaults; Giris 5, 10, 15, 30 accepted back-to-back, cikis_hazir = 1 -> one cycle after the 4th accept, Cikis = 60 (0x3C), tasma = 0, sayac = 4; one cycle later FSM is in TOPLA with giris_hazir = 1.
REQ-030 Result pending; cikis_hazir = 0 for 3 cycles with giris_gecerli = 1 and Giris = 7 -> Cikis stays 60, giris_hazir = 0, no accept; transfer on the 4th cycle, next sum starts from 0.
REQ-031 ADET = 10; ten sums of 30 -> Cikis = 44 (300 mod 256), tasma = 1; tasma clears after transfer.
REQ-032 Two sums 20 and 9 accepted, then temizle asserted together with a valid Giris = 3 -> sayac = 0, acc = 0; then 1, 2, 3, 4 -> Cikis = 10.
REQ-033 rst pulsed asynchronously after 2 accepts and again during SUN -> all outputs return to reset values immediately; a following sequence 1, 1, 1, 1 gives Cikis = 4.
REQ-034 Random giris_gecerli/cikis_hazir over 1000 results -> every Cikis equals the scoreboard sum modulo 256, with no lost or duplicated inputs.
